mux_pipe: RTL and testbench
===========================

// Module: mux_pipe
// PURPOSE
//   Parametrised N-input select with a registered 2-entry skid-buffered output stage.
//   Picks one of NUM_IN WIDTH-bit channels per transfer and holds it under downstream backpressure.
//   Sits between decode and the EX/WB pipeline registers for register-destination select
//   (rt/rd/$ra), and serves as the general stall-safe operand selector.
// PARAMETERS
//   WIDTH   5  bit width of each channel and of out_z
//   NUM_IN  2  number of input channels; legal range 2..16
//   SEL_W   1  select width; 2**SEL_W >= NUM_IN is required, elaboration fails otherwise
// PORTS
//   in_clk      in   1              clock, all state on rising edge
//   in_rst      in   1              synchronous active-high reset
//   in_data     in   WIDTH*NUM_IN   packed channels; channel k = in_data[k*WIDTH +: WIDTH]
//   in_select   in   SEL_W          channel index, sampled with in_valid
//   in_valid    in   1              upstream offers a transfer
//   out_ready   out  1              block can accept; = ~skid_valid
//   out_z       out  WIDTH          selected data at head of buffer
//   out_valid   out  1              out_z holds a valid entry
//   in_ready    in   1              downstream accepts head this cycle
//   out_sel_err out  1              head entry was captured with in_select >= NUM_IN
//   in_flush    in   1              discard all buffered entries
//   out_count   out  2              occupancy, 0..2
// BEHAVIOUR
//   Reset (in_rst=1 at edge): out_valid=0, out_z=0, out_sel_err=0, out_count=0, out_ready=1 next cycle.
//   Reset overrides flush, accept and pop.
//   Select: combinational on in_select.
//     - in_select < NUM_IN: chosen channel.
//     - in_select >= NUM_IN: value is 0 and the err bit is set. It is stored with the entry.
//   Accept = in_valid & out_ready. Pop = out_valid & in_ready.
//   Storage: main entry (drives out_z/out_valid/out_sel_err) plus skid entry.
//   Each entry holds WIDTH data bits, the err bit and a valid bit.
//   Transitions per edge, by occupancy:
//     - EMPTY: accept -> main loaded, occupancy ONE. Latency 1 cycle, accept to out_valid.
//     - ONE, accept & pop: main reloaded with new data, stays ONE. Full throughput, no bubble.
//     - ONE, accept only: new data to skid, occupancy FULL, out_ready=0 next cycle.
//     - ONE, pop only: occupancy EMPTY.
//     - FULL, pop: skid moves to main, skid cleared, occupancy ONE. No accept is possible while FULL.
//   Order is strict FIFO; no entry is duplicated or dropped except by flush or reset.
//   out_z and out_sel_err are stable while out_valid=1 and in_ready=0.
//   out_z = 0 whenever out_valid=0. Cleared entries are zeroed.
//   in_flush=1: both entries are cleared next cycle and occupancy goes EMPTY.
//     - A same-cycle accept is discarded.
//     - A same-cycle pop still completes on the consumer side; the data is not re-presented.
//   out_ready is a registered function of state only. There is no combinational path from in_ready.
//   in_data/in_select are ignored when in_valid=0.
// TESTING
//   1. Reset, then in_valid=1, sel=1, ch0=5'h03, ch1=5'h1F, in_ready=1
//      -> next cycle out_valid=1, out_z=5'h1F, out_count=1.
//   2. Stream 8 back-to-back transfers with in_ready=1 throughout
//      -> 8 outputs on consecutive cycles, in order, out_ready never 0.
//   3. in_ready=0, push A=5'h0A then B=5'h0B
//      -> out_count=2, out_ready=0, out_z=0A held; in_ready=1 -> 0A, then 0B, out_ready=1.
//   4. NUM_IN=3, SEL_W=2, push sel=3
//      -> out_z=0, out_sel_err=1; the next push with sel=2 gives ch2 with out_sel_err=0.
//   5. FULL with in_ready=0, assert in_flush together with in_valid=1
//      -> next cycle out_valid=0, out_count=0, out_z=0, the new data is absent.
//   6. in_rst=1 while FULL with in_valid=1
//      -> next cycle all outputs at reset values, out_ready=1; reset wins over flush and accept.

Source files
------------

// File: rtl/mux_pipe_if.sv
// Handshake bundle for mux_pipe: upstream transfer, downstream head, and flush/occupancy.
// The slave modport is the mux_pipe view; the master modport is the surrounding pipeline.
interface mux_pipe_if #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = 1
);
  logic [WIDTH*NUM_IN-1:0] in_data;
  logic [SEL_W-1:0]        in_select;
  logic                    in_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_z;
  logic                    out_valid;
  logic                    in_ready;
  logic                    out_sel_err;
  logic                    in_flush;
  logic [1:0]              out_count;

  modport slave (
    input  in_data, in_select, in_valid, in_ready, in_flush,
    output out_ready, out_z, out_valid, out_sel_err, out_count
  );

  modport master (
    output in_data, in_select, in_valid, in_ready, in_flush,
    input  out_ready, out_z, out_valid, out_sel_err, out_count
  );
endinterface

// File: rtl/mux_pipe.sv
// N-input channel select feeding a 2-entry skid-buffered output stage.
// Out-of-range selects yield zero data and carry an error flag with the entry.
module mux_pipe #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = 1
) (
  input logic       in_clk,
  input logic       in_rst,
  mux_pipe_if.slave bus
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  if ((1 << SEL_W) < NUM_IN) begin : g_sel_w_check
    $error("mux_pipe: SEL_W too narrow to address NUM_IN channels");
  end
  if (NUM_IN < 2 || NUM_IN > 16) begin : g_num_in_check
    $error("mux_pipe: NUM_IN must be in 2..16");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             main_err;
  logic             skid_err;
  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic             accept;
  logic             pop;

  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (bus.in_select == SEL_W'(k)) begin
        sel_data = bus.in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  // Ready depends on the registered occupancy only, never on in_ready.
  assign bus.out_ready   = (state != FULL);
  assign bus.out_valid   = (state != EMPTY);
  assign bus.out_z       = main_data;
  assign bus.out_sel_err = main_err;
  assign bus.out_count   = state;

  assign accept = bus.in_valid & bus.out_ready;
  assign pop    = bus.out_valid & bus.in_ready;

  always_ff @(posedge in_clk) begin
    if (in_rst || bus.in_flush) begin
      state     <= EMPTY;
      main_data <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data <= sel_data;
            main_err  <= sel_err;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_data <= sel_data;
            main_err  <= sel_err;
          end else if (accept) begin
            skid_data <= sel_data;
            skid_err  <= sel_err;
            state     <= FULL;
          end else if (pop) begin
            main_data <= '0;
            main_err  <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_data <= skid_data;
            main_err  <= skid_err;
            skid_data <= '0;
            skid_err  <= 1'b0;
            state     <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          main_data <= '0;
          main_err  <= 1'b0;
          skid_data <= '0;
          skid_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_pipe.sv
// Bench for mux_pipe (WIDTH=5, NUM_IN=3, SEL_W=2): directed scenarios then random traffic,
// checked every cycle against a queue model of the 2-deep buffer.
module tb_mux_pipe;
  localparam int WIDTH  = 5;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;

  logic in_clk = 1'b0;
  logic in_rst = 1'b1;
  always #5 in_clk = ~in_clk;

  mux_pipe_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

  mux_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (bus)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [WIDTH-1:0] ch [NUM_IN];
  logic [WIDTH:0]   q  [$];   // {err, data}, head at index 0

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [SEL_W-1:0] sel, input logic rdy,
                       input logic fl, input logic rs);
    bus.in_valid  = v;
    bus.in_select = sel;
    bus.in_ready  = rdy;
    bus.in_flush  = fl;
    in_rst        = rs;
    for (int i = 0; i < NUM_IN; i++) bus.in_data[i*WIDTH +: WIDTH] = ch[i];
  endtask

  // What the buffer would store for the currently offered transfer.
  function automatic logic [WIDTH:0] offered();
    int s;
    s = int'(bus.in_select);
    if (s < NUM_IN) return {1'b0, ch[s]};
    return {1'b1, {WIDTH{1'b0}}};
  endfunction

  task automatic step(input string tag);
    int n;
    logic acc;
    logic [WIDTH:0] e;
    n   = q.size();
    acc = bus.in_valid && (n < 2);
    e   = offered();
    @(posedge in_clk);
    if (in_rst || bus.in_flush) q.delete();
    else begin
      if (n > 0 && bus.in_ready) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
    check({tag, ".count"}, 8'(bus.out_count), 8'(q.size()));
    check({tag, ".valid"}, 8'(bus.out_valid), 8'(q.size() > 0));
    check({tag, ".ready"}, 8'(bus.out_ready), 8'(q.size() < 2));
    check({tag, ".z"},     8'(bus.out_z),     (q.size() > 0) ? 8'(q[0][WIDTH-1:0]) : 8'h00);
    check({tag, ".err"},   8'(bus.out_sel_err), (q.size() > 0) ? 8'(q[0][WIDTH]) : 8'h00);
  endtask

  initial begin
    for (int i = 0; i < NUM_IN; i++) ch[i] = '0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step("reset0");
    step("reset1");

    // Single transfer: channel 1 selected.
    ch[0] = 5'h03; ch[1] = 5'h1F; ch[2] = 5'h11;
    drive(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    step("t1");
    check("t1.z_const", 8'(bus.out_z), 8'h1F);

    // Eight back-to-back transfers with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < NUM_IN; c++) ch[c] = WIDTH'($urandom);
      drive(1'b1, SEL_W'($urandom_range(0, NUM_IN - 1)), 1'b1, 1'b0, 1'b0);
      step("t2");
      check("t2.ready_const", 8'(bus.out_ready), 8'h01);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("t2.drain");

    // Backpressure: A then B stall, then drain in order.
    ch[0] = 5'h0A;
    drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step("t3.a");
    ch[0] = 5'h0B;
    drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step("t3.b");
    check("t3.full_count", 8'(bus.out_count), 8'h02);
    check("t3.held_z", 8'(bus.out_z), 8'h0A);
    ch[0] = 5'h15;
    drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step("t3.hold");
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step("t3.pop1");
    check("t3.second_z", 8'(bus.out_z), 8'h0B);
    step("t3.pop2");

    // Out-of-range select, then channel 2.
    ch[2] = 5'h17;
    drive(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    step("t4.bad");
    check("t4.bad_err", 8'(bus.out_sel_err), 8'h01);
    drive(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    step("t4.good");
    check("t4.good_z", 8'(bus.out_z), 8'h17);
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step("t4.drain");

    // Flush while full with a concurrent offer.
    drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    step("t5.f1");
    step("t5.f2");
    drive(1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    step("t5.flush");
    check("t5.empty", 8'(bus.out_count), 8'h00);

    // Reset while full with offer and flush: reset wins.
    drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step("t6.f1");
    step("t6.f2");
    drive(1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
    step("t6.rst");
    check("t6.ready", 8'(bus.out_ready), 8'h01);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NUM_IN; c++) ch[c] = WIDTH'($urandom);
      drive(1'($urandom_range(0, 3) != 0), SEL_W'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 60) == 0));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
